// File: rtl/step_ctrl_pkg.sv
// Shared types for the debug-CPU execution controller.
// FSM states and run-mode encodings.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    BURST,
    RUN
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SINGLE = 2'b00;
  localparam mode_t MODE_BURST  = 2'b01;
  localparam mode_t MODE_RUNBP  = 2'b10;
  localparam mode_t MODE_FREE   = 2'b11;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Button synchroniser and debouncer for the step controller.
// Emits a one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      level       <= 1'b0;
      press_pulse <= 1'b0;
      cnt         <= '0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      press_pulse <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level       <= s2;
        press_pulse <= s2;
        cnt         <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Debug-CPU execution controller: single/burst/run-to-bp/free-run.
// Optional RUN watchdog enabled by STEP_CTRL_WATCHDOG_EN.
module cpu_step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_W            = 32,
  parameter int STEP_W          = 16,
  parameter int CNT_W           = 32,
  parameter int RUN_TIMEOUT     = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_step,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] burst_len,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_valid,
  input  logic [PC_W-1:0]   cpu_pc,
  input  logic              halt_req,
  input  logic              clr_cnt,
  output logic              clk_en,
  output logic              running,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  step_cnt,
  output logic              timeout
);

  state_t            state;
  state_t            state_nx;
  logic              btn_level;
  logic              press_pulse;
  logic              press;
  logic              bp_chk;
  logic              run_first;
  logic [STEP_W-1:0] rem;
  logic              clk_en_c;
  logic              bp_match;
  logic              abort;
  logic              wd_fire;
  logic              set_hit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .resetn     (resetn),
    .btn_raw    (btn_step),
    .level      (btn_level),
    .press_pulse(press_pulse)
  );

  assign press = press_pulse & btn_level;

  // first RUN cycle ignores a match so a run can leave the bp
  assign bp_match = bp_chk && bp_valid &&
                    (cpu_pc == bp_addr) && !run_first;

  assign abort = (state != IDLE) &&
                 (halt_req ||
                  (press && (state == BURST ||
                             state == RUN)));

  assign set_hit = (state == RUN) && bp_match &&
                   !wd_fire && !abort;

  always_comb begin
    state_nx = state;
    clk_en_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (press) begin
          unique case (1'b1)
            (mode == MODE_SINGLE): state_nx = STEP;
            (mode == MODE_BURST):  state_nx = BURST;
            (mode == MODE_RUNBP):  state_nx = RUN;
            (mode == MODE_FREE):   state_nx = RUN;
            default:               state_nx = IDLE;
          endcase
        end
      end
      STEP: begin
        clk_en_c = 1'b1;
        state_nx = IDLE;
      end
      BURST: begin
        clk_en_c = 1'b1;
        if (rem == STEP_W'(1)) state_nx = IDLE;
      end
      RUN: begin
        if (wd_fire || bp_match) state_nx = IDLE;
        else clk_en_c = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      clk_en_c = 1'b0;
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bp_chk    <= 1'b0;
      run_first <= 1'b1;
      rem       <= '0;
      bp_hit    <= 1'b0;
      step_cnt  <= '0;
    end else begin
      state     <= state_nx;
      run_first <= (state != RUN);
      if (state == IDLE && press) begin
        bp_chk <= (mode == MODE_RUNBP);
        rem    <= (burst_len == '0) ?
                  STEP_W'(1) : burst_len;
      end else if (state == BURST && clk_en_c) begin
        rem <= rem - 1'b1;
      end
      if (press) bp_hit <= 1'b0;
      else if (set_hit) bp_hit <= 1'b1;
      if (clr_cnt) step_cnt <= '0;
      else if (clk_en_c) step_cnt <= step_cnt + 1'b1;
    end
  end

`ifdef STEP_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(RUN_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            set_to;
  logic            to_q;

  assign wd_fire = (state == RUN) &&
                   (wd_cnt == WD_W'(RUN_TIMEOUT));
  assign set_to  = wd_fire && !abort;
  assign timeout = to_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state != RUN) wd_cnt <= '0;
      else if (clk_en_c) wd_cnt <= wd_cnt + 1'b1;
      if (press) to_q <= 1'b0;
      else if (set_to) to_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // reset forces the gate open so the CPU sees its own reset
  assign clk_en  = clk_en_c | ~resetn;
  assign running = (state != IDLE);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl (DEBOUNCE_CYCLES=4).
// Stimulus queues expected outputs; a negedge monitor compares.
module tb_cpu_step_ctrl;

  logic        clk;
  logic        resetn;
  logic        btn_step;
  logic [1:0]  mode;
  logic [15:0] burst_len;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic [31:0] cpu_pc;
  logic        halt_req;
  logic        clr_cnt;
  logic        clk_en;
  logic        running;
  logic        bp_hit;
  logic [31:0] step_cnt;
  logic        timeout;

  typedef struct {
    string       tag;
    logic        en;
    logic        run;
    logic        hit;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  localparam int WAIT_LIMIT = 200000;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [31:0] exp_cnt;
  logic        exp_hit;
  logic        exp_to;
  logic [31:0] pc;
  logic        done;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PC_W(32),
    .STEP_W(16),
    .CNT_W(32),
    .RUN_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .btn_step(btn_step),
    .mode(mode),
    .burst_len(burst_len),
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .cpu_pc(cpu_pc),
    .halt_req(halt_req),
    .clr_cnt(clr_cnt),
    .clk_en(clk_en),
    .running(running),
    .bp_hit(bp_hit),
    .step_cnt(step_cnt),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    done = 1'b0;
    #(WAIT_LIMIT);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_limit: bench did not finish");
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (clk_en !== e.en || running !== e.run ||
          bp_hit !== e.hit || timeout !== e.to ||
          step_cnt !== e.cnt) begin
        errors++;
        $display({"FAIL %s: got en=%b run=%b hit=%b",
                  " to=%b cnt=%0d, want en=%b run=%b",
                  " hit=%b to=%b cnt=%0d"},
                 e.tag, clk_en, running, bp_hit,
                 timeout, step_cnt, e.en, e.run,
                 e.hit, e.to, e.cnt);
      end
    end
  end

  task automatic step(input string tag,
                      input logic en,
                      input logic run);
    exp_t e;
    e.tag = tag;
    e.en  = en;
    e.run = run;
    e.hit = exp_hit;
    e.to  = exp_to;
    e.cnt = exp_cnt;
    sb.push_back(e);
    if (!resetn) exp_cnt = 0;
    else if (clr_cnt) exp_cnt = 0;
    else if (en) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
  endtask

  task automatic press_btn(input logic busy,
                           input string tag);
    btn_step = 1'b1;
    for (int i = 0; i < 6; i++) step(tag, busy, busy);
    step({tag, "_press"}, 1'b0, busy);
    exp_hit  = 1'b0;
    exp_to   = 1'b0;
    btn_step = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cnt   = 0;
    exp_hit   = 0;
    exp_to    = 0;
    pc        = 0;
    resetn    = 1'b0;
    btn_step  = 1'b0;
    mode      = 2'b00;
    burst_len = 16'd0;
    bp_addr   = 32'd0;
    bp_valid  = 1'b0;
    cpu_pc    = 32'd0;
    halt_req  = 1'b0;
    clr_cnt   = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) step("reset", 1'b1, 1'b0);
    resetn = 1'b1;
    step("release", 1'b0, 1'b0);
    checks++;
    if (clk_en !== 1'b0 || running !== 1'b0 ||
        bp_hit !== 1'b0 || timeout !== 1'b0 ||
        step_cnt !== 32'd0) begin
      errors++;
      $display({"FAIL reset_state: en=%b run=%b",
                " hit=%b to=%b cnt=%0d"},
               clk_en, running, bp_hit, timeout,
               step_cnt);
    end
    idle(3, "idle0");

    mode = 2'b00;
    for (int i = 0; i < 25; i++) begin
      if (i < 4) btn_step = (i % 2 == 0);
      else btn_step = (i < 14);
      step("bounce", i == 11, i == 11);
    end
    idle(2, "single_done");

    mode = 2'b01;
    burst_len = 16'd5;
    press_btn(1'b0, "b5");
    mode = 2'b00;
    burst_len = 16'd9;
    for (int i = 0; i < 5; i++) step("burst5", 1'b1, 1'b1);
    step("burst5_end", 1'b0, 1'b0);
    idle(4, "gap");

    mode = 2'b01;
    burst_len = 16'd0;
    press_btn(1'b0, "b0");
    step("burst0", 1'b1, 1'b1);
    step("burst0_end", 1'b0, 1'b0);
    idle(4, "gap");

    burst_len = 16'd30;
    press_btn(1'b0, "b30");
    for (int i = 0; i < 8; i++) step("burst30", 1'b1, 1'b1);
    press_btn(1'b1, "abort");
    step("abort_idle", 1'b0, 1'b0);
    idle(4, "gap");

    halt_req = 1'b1;
    step("halt_in_idle", 1'b0, 1'b0);
    halt_req = 1'b0;

    mode = 2'b10;
    bp_addr = 32'h10;
    bp_valid = 1'b1;
    pc = 0;
    cpu_pc = pc;
    press_btn(1'b0, "rbp");
    for (int i = 0; i < 4; i++) begin
      cpu_pc = pc;
      step("rbp_run", 1'b1, 1'b1);
      pc = pc + 4;
    end
    cpu_pc = pc;
    step("bp_stop", 1'b0, 1'b1);
    exp_hit = 1'b1;
    step("bp_idle", 1'b0, 1'b0);
    idle(4, "bp_gap");

    press_btn(1'b0, "rbp2");
    for (int i = 0; i < 4; i++) begin
      cpu_pc = pc;
      step(i == 0 ? "bp_past" : "rbp2_run",
           1'b1, 1'b1);
      pc = pc + 4;
    end
    cpu_pc = pc;
    halt_req = 1'b1;
    step("rbp2_halt", 1'b0, 1'b1);
    halt_req = 1'b0;
    step("rbp2_idle", 1'b0, 1'b0);
    idle(4, "gap");

    clr_cnt = 1'b1;
    step("clr", 1'b0, 1'b0);
    clr_cnt = 1'b0;

    mode = 2'b11;
    pc = 32'h20;
    bp_addr = 32'h28;
    cpu_pc = pc;
    press_btn(1'b0, "free");
    for (int i = 0; i < 6; i++) begin
      cpu_pc = pc;
      step("free_run", 1'b1, 1'b1);
      pc = pc + 4;
    end
    cpu_pc = pc;
    halt_req = 1'b1;
    step("free_halt", 1'b0, 1'b1);
    halt_req = 1'b0;
    step("free_cnt6", 1'b0, 1'b0);
    idle(4, "gap");

    mode = 2'b00;
    press_btn(1'b0, "clr_en");
    clr_cnt = 1'b1;
    step("clr_with_en", 1'b1, 1'b1);
    clr_cnt = 1'b0;
    step("clr_after", 1'b0, 1'b0);
    idle(4, "gap");

`ifdef STEP_CTRL_WATCHDOG_EN
    mode = 2'b10;
    bp_addr = 32'hFFFF_FFF0;
    cpu_pc = 32'd0;
    press_btn(1'b0, "wd");
    for (int i = 0; i < 20; i++) step("wd_run", 1'b1, 1'b1);
    step("wd_fire", 1'b0, 1'b1);
    exp_to = 1'b1;
    step("wd_idle", 1'b0, 1'b0);
    idle(4, "wd_gap");
    mode = 2'b00;
    press_btn(1'b0, "wd_clr");
    step("wd_clr_step", 1'b1, 1'b1);
    step("wd_clr_idle", 1'b0, 1'b0);
    idle(4, "gap");
`endif

    mode = 2'b01;
    burst_len = 16'd10;
    press_btn(1'b0, "rb");
    step("rb_run", 1'b1, 1'b1);
    step("rb_run", 1'b1, 1'b1);
    resetn = 1'b0;
    exp_cnt = 0;
    exp_hit = 1'b0;
    exp_to = 1'b0;
    step("async_rst", 1'b1, 1'b0);
    step("async_rst", 1'b1, 1'b0);
    resetn = 1'b1;
    step("post_rst", 1'b0, 1'b0);
    idle(3, "post_rst_idle");

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Parametrised execution controller for the on-board debug CPU. It replaces the fixed single-pulse button gating with a debounced button and four run modes: single-step, N-step burst, run-to-breakpoint and free-run. It produces the clock-enable that drives the CPU clock gate, and keeps an enabled-cycle counter for the LCD display. It sits between the board button/LCD input logic and the CPU clock buffer.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a new button level (>=2)
PC_W, 32, PC/breakpoint width
STEP_W, 16, burst length width
CNT_W, 32, enabled-cycle counter width
RUN_TIMEOUT, 1000000, RUN-mode cycle limit; used only with STEP_CTRL_WATCHDOG_EN

Ports:
clk  in  1  board clock
resetn  in  1  asynchronous active-low reset
btn_step  in  1  raw button, active high, asynchronous
mode  in  2  00 single, 01 burst, 10 run-to-bp, 11 free-run; sampled only on an accepted press
burst_len  in  STEP_W  burst step count; sampled with mode
bp_addr  in  PC_W  breakpoint PC
bp_valid  in  1  breakpoint armed
cpu_pc  in  PC_W  current CPU PC
halt_req  in  1  synchronous abort request
clr_cnt  in  1  clear cycle counter
clk_en  out  1  CPU clock enable (combinational from state and inputs)
running  out  1  state != IDLE
bp_hit  out  1  sticky; set on breakpoint stop, cleared by the next accepted press
step_cnt  out  CNT_W  count of cycles with clk_en=1
timeout  out  1  sticky watchdog flag (constant 0 when the feature is absent)

Behaviour:
- Reset (resetn=0): state=IDLE, clk_en=1 (forced, so the CPU's synchronous reset is clocked), running=0, bp_hit=0, step_cnt=0, timeout=0, debounced level=0. clk_en drops to 0 in the first cycle after release.
- Button path: 2-flop synchroniser, then debounce. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it. An accepted press is a 1-cycle pulse on the debounced 0->1 edge. Button bounces never produce more than one press.
- FSM states: IDLE, STEP, BURST, RUN.
- IDLE: clk_en=0. On press, latch mode and burst_len, clear bp_hit, then:
  - 00 -> STEP
  - 01 -> BURST with rem = max(burst_len, 1)
  - 10 -> RUN with bp checking on
  - 11 -> RUN with bp checking off
- STEP: clk_en=1 for exactly 1 cycle, then IDLE.
- BURST: clk_en=1 every cycle; rem decrements per enabled cycle; when rem==1 is consumed, go to IDLE. Exactly max(burst_len, 1) enables occur.
- RUN: clk_en=1 unless bp checking is on, bp_valid=1 and cpu_pc==bp_addr. The first cycle of RUN ignores a match, so a run started at the breakpoint steps past it. On a match: clk_en=0 in that same cycle, bp_hit<=1, state<=IDLE. No overshoot: the instruction at bp_addr is not executed.
- Abort: a press in BURST or RUN, or halt_req in any non-IDLE state, gives clk_en=0 in that cycle and IDLE next cycle. halt_req takes priority over all other transitions. halt_req in IDLE has no effect.
- Mode and burst_len changes outside an accepted press are ignored.
- step_cnt: +1 on each clk_en=1 cycle after reset; wraps modulo 2^CNT_W. clr_cnt has priority: simultaneous clear and enable gives 0.
- Asynchronous reset mid-burst or mid-run returns everything to the reset values immediately.

Optional Feature:
STEP_CTRL_WATCHDOG_EN
- Defined: a RUN-state cycle counter, cleared on entry to RUN. After RUN_TIMEOUT enabled cycles the controller forces IDLE, clk_en=0 in that cycle, and sets timeout. timeout is cleared by the next press or by reset.
- Undefined: no watchdog logic; timeout tied to 0; RUN is unbounded.

Decomposition:
- Package step_ctrl_pkg: state enum (IDLE/STEP/BURST/RUN), mode encodings MODE_SINGLE/MODE_BURST/MODE_RUNBP/MODE_FREE.
- Sub-module btn_debounce(clk, resetn, btn_raw -> level, press_pulse), parametrised by DEBOUNCE_CYCLES.
- FSM, counters and breakpoint compare stay in cpu_step_ctrl.

Test Plan:
- Reset held 5 cycles: clk_en=1 throughout; release: clk_en=0, step_cnt=0, running=0.
- DEBOUNCE_CYCLES=4, btn toggles 1/0/1/0 each cycle, then stays 1 for 10 cycles: exactly one press; mode=00 gives exactly 1 clk_en cycle and step_cnt=1.
- mode=01, burst_len=5: 5 consecutive clk_en cycles, step_cnt=5, then running=0. burst_len=0: exactly 1 enable.
- mode=10, bp_addr=0x0000_0010, PC model +4 per enable starting at 0: enables at PC 0,4,8,C; clk_en=0 when PC=0x10; bp_hit=1. A second press steps past 0x10 (first cycle ignores the match).
- mode=11 free-run, halt_req pulsed at cycle 7: clk_en=0 in that cycle, IDLE next cycle, step_cnt=6. clr_cnt together with an enable gives step_cnt=0.
- With STEP_CTRL_WATCHDOG_EN and RUN_TIMEOUT=20, mode=10, bp never reached: 20 enables, then timeout=1 and running=0. Assert resetn low mid-burst: outputs return to reset values asynchronously.
